// File: rtl/i2c_cmd_arb_pkg.sv
// i2c_cmd_arb_pkg: shared I2C field widths and pending-data kinds for the command arbiter.
package i2c_cmd_arb_pkg;
    localparam int ADDR_W = 7;
    localparam int DATA_W = 8;
    typedef enum logic [1:0] {PEND_NONE, PEND_WRITE, PEND_READ} pend_t;
endpackage

// File: rtl/i2c_arb_rr.sv
// i2c_arb_rr: two-request grant selection, round-robin or fixed priority to port 0.
module i2c_arb_rr #(
    parameter int ARB_RR = 1
) (
    input  logic [1:0] req_i,
    input  logic       last_grant_i,
    output logic       grant_o,
    output logic       valid_o
);
    assign valid_o = |req_i;
    assign grant_o = &req_i ? ((ARB_RR != 0) ? ~last_grant_i : 1'b0) : req_i[1];
endmodule

// File: rtl/i2c_cmd_arb.sv
// i2c_cmd_arb: arbitrates two I2C command/data ports onto one I2C master.
// The grant is held until a stop command completes and its data phase drains.
module i2c_cmd_arb
    import i2c_cmd_arb_pkg::*;
#(
    parameter int ARB_RR = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] s0_cmd_address,
    input  logic              s0_cmd_start,
    input  logic              s0_cmd_read,
    input  logic              s0_cmd_write,
    input  logic              s0_cmd_write_multiple,
    input  logic              s0_cmd_stop,
    input  logic              s0_cmd_valid,
    output logic              s0_cmd_ready,
    input  logic [DATA_W-1:0] s0_data_out,
    input  logic              s0_data_out_valid,
    input  logic              s0_data_out_last,
    output logic              s0_data_out_ready,
    output logic [DATA_W-1:0] s0_data_in,
    output logic              s0_data_in_valid,
    output logic              s0_data_in_last,
    input  logic              s0_data_in_ready,
    input  logic [ADDR_W-1:0] s1_cmd_address,
    input  logic              s1_cmd_start,
    input  logic              s1_cmd_read,
    input  logic              s1_cmd_write,
    input  logic              s1_cmd_write_multiple,
    input  logic              s1_cmd_stop,
    input  logic              s1_cmd_valid,
    output logic              s1_cmd_ready,
    input  logic [DATA_W-1:0] s1_data_out,
    input  logic              s1_data_out_valid,
    input  logic              s1_data_out_last,
    output logic              s1_data_out_ready,
    output logic [DATA_W-1:0] s1_data_in,
    output logic              s1_data_in_valid,
    output logic              s1_data_in_last,
    input  logic              s1_data_in_ready,
    output logic [ADDR_W-1:0] m_cmd_address,
    output logic              m_cmd_start,
    output logic              m_cmd_read,
    output logic              m_cmd_write,
    output logic              m_cmd_write_multiple,
    output logic              m_cmd_stop,
    output logic              m_cmd_valid,
    input  logic              m_cmd_ready,
    output logic [DATA_W-1:0] m_data_out,
    output logic              m_data_out_valid,
    output logic              m_data_out_last,
    input  logic              m_data_out_ready,
    input  logic [DATA_W-1:0] m_data_in,
    input  logic              m_data_in_valid,
    input  logic              m_data_in_last,
    output logic              m_data_in_ready,
    output logic              grant,
    output logic              busy
);
    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] ACTIVE = 2'd1;
    localparam logic [1:0] DRAIN  = 2'd2;

    logic [1:0] state_q, state_d;
    logic       grant_q, grant_d, last_q, last_d;
    pend_t      pend_q, pend_d, stop_kind;
    logic       arb_idx, arb_valid, act, cmd_en, out_done, in_done, stop_done, drain_done;

    i2c_arb_rr #(.ARB_RR(ARB_RR)) u_arb (
        .req_i        ({s1_cmd_valid, s0_cmd_valid}),
        .last_grant_i (last_q),
        .grant_o      (arb_idx),
        .valid_o      (arb_valid)
    );

    assign act    = state_q != IDLE;
    assign cmd_en = state_q == ACTIVE;
    assign busy   = act;
    assign grant  = grant_q;

    assign m_cmd_address        = grant_q ? s1_cmd_address : s0_cmd_address;
    assign m_cmd_start          = grant_q ? s1_cmd_start : s0_cmd_start;
    assign m_cmd_read           = grant_q ? s1_cmd_read : s0_cmd_read;
    assign m_cmd_write          = grant_q ? s1_cmd_write : s0_cmd_write;
    assign m_cmd_write_multiple = grant_q ? s1_cmd_write_multiple : s0_cmd_write_multiple;
    assign m_cmd_stop           = grant_q ? s1_cmd_stop : s0_cmd_stop;
    assign m_cmd_valid          = cmd_en & (grant_q ? s1_cmd_valid : s0_cmd_valid);
    assign m_data_out           = grant_q ? s1_data_out : s0_data_out;
    assign m_data_out_last      = grant_q ? s1_data_out_last : s0_data_out_last;
    assign m_data_out_valid     = act & (grant_q ? s1_data_out_valid : s0_data_out_valid);
    assign m_data_in_ready      = act & (grant_q ? s1_data_in_ready : s0_data_in_ready);

    assign s0_cmd_ready      = cmd_en & ~grant_q & m_cmd_ready;
    assign s1_cmd_ready      = cmd_en & grant_q & m_cmd_ready;
    assign s0_data_out_ready = act & ~grant_q & m_data_out_ready;
    assign s1_data_out_ready = act & grant_q & m_data_out_ready;
    assign s0_data_in        = m_data_in;
    assign s1_data_in        = m_data_in;
    assign s0_data_in_last   = m_data_in_last;
    assign s1_data_in_last   = m_data_in_last;
    assign s0_data_in_valid  = act & ~grant_q & m_data_in_valid;
    assign s1_data_in_valid  = act & grant_q & m_data_in_valid;

    assign out_done   = m_data_out_valid & m_data_out_ready & m_data_out_last;
    assign in_done    = m_data_in_valid & m_data_in_ready & m_data_in_last;
    assign stop_kind  = (m_cmd_write | m_cmd_write_multiple) ? PEND_WRITE : m_cmd_read ? PEND_READ : PEND_NONE;
    assign stop_done  = stop_kind == PEND_WRITE ? out_done : stop_kind == PEND_READ ? in_done : 1'b1;
    assign drain_done = pend_q == PEND_WRITE ? out_done : pend_q == PEND_READ ? in_done : 1'b1;

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        last_d  = last_q;
        pend_d  = pend_q;
        if (state_q == IDLE) begin
            if (arb_valid) begin
                state_d = ACTIVE;
                grant_d = arb_idx;
                last_d  = arb_idx;
            end
        end else if (state_q == ACTIVE) begin
            // a data handshake coinciding with the stop handshake skips DRAIN
            if (m_cmd_valid & m_cmd_ready & m_cmd_stop) begin
                pend_d  = stop_kind;
                state_d = stop_done ? IDLE : DRAIN;
            end
        end else if (state_q == DRAIN) begin
            if (drain_done) state_d = IDLE;
        end else begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            grant_q <= 1'b0;
            last_q  <= 1'b1;
            pend_q  <= PEND_NONE;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
            pend_q  <= pend_d;
        end
    end
endmodule

// File: tb/tb_i2c_cmd_arb.sv
// tb_i2c_cmd_arb: directed checks of grant selection, pass-through, drain and reset behaviour.
module tb_i2c_cmd_arb;
    logic       clk = 1'b0, rst_n = 1'b0;
    logic [6:0] s0_cmd_address = '0, s1_cmd_address = '0, m_cmd_address;
    logic       s0_cmd_start = 0, s0_cmd_read = 0, s0_cmd_write = 0, s0_cmd_write_multiple = 0, s0_cmd_stop = 0, s0_cmd_valid = 0;
    logic       s1_cmd_start = 0, s1_cmd_read = 0, s1_cmd_write = 0, s1_cmd_write_multiple = 0, s1_cmd_stop = 0, s1_cmd_valid = 0;
    logic       s0_cmd_ready, s1_cmd_ready, s0_data_out_ready, s1_data_out_ready;
    logic [7:0] s0_data_out = '0, s1_data_out = '0, s0_data_in, s1_data_in, m_data_out, m_data_in = '0;
    logic       s0_data_out_valid = 0, s0_data_out_last = 0, s1_data_out_valid = 0, s1_data_out_last = 0;
    logic       s0_data_in_valid, s0_data_in_last, s1_data_in_valid, s1_data_in_last;
    logic       s0_data_in_ready = 0, s1_data_in_ready = 0;
    logic       m_cmd_start, m_cmd_read, m_cmd_write, m_cmd_write_multiple, m_cmd_stop, m_cmd_valid;
    logic       m_cmd_ready = 1, m_data_out_valid, m_data_out_last, m_data_out_ready = 1;
    logic       m_data_in_valid = 0, m_data_in_last = 0, m_data_in_ready, grant, busy;
    int         total = 0, bad = 0;

    i2c_cmd_arb dut (
        .clk(clk), .rst_n(rst_n),
        .s0_cmd_address(s0_cmd_address), .s0_cmd_start(s0_cmd_start), .s0_cmd_read(s0_cmd_read),
        .s0_cmd_write(s0_cmd_write), .s0_cmd_write_multiple(s0_cmd_write_multiple), .s0_cmd_stop(s0_cmd_stop),
        .s0_cmd_valid(s0_cmd_valid), .s0_cmd_ready(s0_cmd_ready),
        .s0_data_out(s0_data_out), .s0_data_out_valid(s0_data_out_valid), .s0_data_out_last(s0_data_out_last),
        .s0_data_out_ready(s0_data_out_ready), .s0_data_in(s0_data_in), .s0_data_in_valid(s0_data_in_valid),
        .s0_data_in_last(s0_data_in_last), .s0_data_in_ready(s0_data_in_ready),
        .s1_cmd_address(s1_cmd_address), .s1_cmd_start(s1_cmd_start), .s1_cmd_read(s1_cmd_read),
        .s1_cmd_write(s1_cmd_write), .s1_cmd_write_multiple(s1_cmd_write_multiple), .s1_cmd_stop(s1_cmd_stop),
        .s1_cmd_valid(s1_cmd_valid), .s1_cmd_ready(s1_cmd_ready),
        .s1_data_out(s1_data_out), .s1_data_out_valid(s1_data_out_valid), .s1_data_out_last(s1_data_out_last),
        .s1_data_out_ready(s1_data_out_ready), .s1_data_in(s1_data_in), .s1_data_in_valid(s1_data_in_valid),
        .s1_data_in_last(s1_data_in_last), .s1_data_in_ready(s1_data_in_ready),
        .m_cmd_address(m_cmd_address), .m_cmd_start(m_cmd_start), .m_cmd_read(m_cmd_read),
        .m_cmd_write(m_cmd_write), .m_cmd_write_multiple(m_cmd_write_multiple), .m_cmd_stop(m_cmd_stop),
        .m_cmd_valid(m_cmd_valid), .m_cmd_ready(m_cmd_ready),
        .m_data_out(m_data_out), .m_data_out_valid(m_data_out_valid), .m_data_out_last(m_data_out_last),
        .m_data_out_ready(m_data_out_ready), .m_data_in(m_data_in), .m_data_in_valid(m_data_in_valid),
        .m_data_in_last(m_data_in_last), .m_data_in_ready(m_data_in_ready),
        .grant(grant), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_grant", grant, 0);
        chk("rst_mvalid", m_cmd_valid, 0);
        cyc();
        rst_n = 1'b1;
    endtask

    initial begin
        // port 0 write of 0x11 to 0x50 with stop
        do_reset();
        chk("idle_s0rdy", s0_cmd_ready, 0);
        s0_cmd_address = 7'h50; s0_cmd_start = 1; s0_cmd_write = 1; s0_cmd_stop = 1; s0_cmd_valid = 1;
        #1;
        chk("idle_mvalid", m_cmd_valid, 0);
        chk("idle_s0rdy_req", s0_cmd_ready, 0);
        cyc();
        chk("w_busy", busy, 1);
        chk("w_grant", grant, 0);
        chk("w_mvalid", m_cmd_valid, 1);
        chk("w_addr", m_cmd_address, 7'h50);
        chk("w_write", m_cmd_write, 1);
        chk("w_s0rdy", s0_cmd_ready, 1);
        chk("w_s1rdy", s1_cmd_ready, 0);
        cyc();
        chk("drain_busy", busy, 1);
        chk("drain_block_mvalid", m_cmd_valid, 0);
        chk("drain_block_s0rdy", s0_cmd_ready, 0);
        s0_cmd_valid = 0; s0_cmd_start = 0; s0_cmd_write = 0; s0_cmd_stop = 0;
        s0_data_out = 8'h11; s0_data_out_valid = 1; s0_data_out_last = 1;
        #1;
        chk("w_data", m_data_out, 8'h11);
        chk("w_dvalid", m_data_out_valid, 1);
        chk("w_dlast", m_data_out_last, 1);
        chk("w_s0drdy", s0_data_out_ready, 1);
        chk("w_s1drdy", s1_data_out_ready, 0);
        cyc();
        chk("w_done_busy", busy, 0);
        s0_data_out_valid = 0; s0_data_out_last = 0;
        cyc();
        cyc();
        chk("idle_hold", busy, 0);

        // simultaneous requests with stop-only commands
        do_reset();
        s0_cmd_stop = 1; s0_cmd_valid = 1; s1_cmd_stop = 1; s1_cmd_valid = 1;
        cyc();
        chk("rr_first_grant", grant, 0);
        chk("rr_first_s1rdy", s1_cmd_ready, 0);
        chk("rr_first_s0rdy", s0_cmd_ready, 1);
        cyc();
        chk("stoponly_idle", busy, 0);
        cyc();
        chk("rr_second_grant", grant, 1);
        chk("rr_second_s1rdy", s1_cmd_ready, 1);
        chk("rr_second_s0rdy", s0_cmd_ready, 0);
        s0_cmd_valid = 0; s0_cmd_stop = 0;
        cyc();
        chk("rr_second_idle", busy, 0);
        s1_cmd_valid = 0; s1_cmd_stop = 0;

        // port 1 read of 0x51 with delayed read-data acceptance
        s1_cmd_address = 7'h51; s1_cmd_start = 1; s1_cmd_read = 1; s1_cmd_stop = 1; s1_cmd_valid = 1;
        cyc();
        chk("r_grant", grant, 1);
        chk("r_addr", m_cmd_address, 7'h51);
        chk("r_read", m_cmd_read, 1);
        cyc();
        s1_cmd_valid = 0; s1_cmd_start = 0; s1_cmd_read = 0; s1_cmd_stop = 0;
        m_data_in = 8'hA5; m_data_in_valid = 1; m_data_in_last = 1;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("r_wait_busy", busy, 1);
            chk("r_wait_mrdy", m_data_in_ready, 0);
            chk("r_wait_s0v", s0_data_in_valid, 0);
            chk("r_wait_s1v", s1_data_in_valid, 1);
            cyc();
        end
        s1_data_in_ready = 1;
        #1;
        chk("r_mrdy", m_data_in_ready, 1);
        chk("r_s1data", s1_data_in, 8'hA5);
        chk("r_s1last", s1_data_in_last, 1);
        chk("r_s0v", s0_data_in_valid, 0);
        cyc();
        chk("r_done_busy", busy, 0);
        m_data_in_valid = 0; m_data_in_last = 0; s1_data_in_ready = 0;

        // stop write whose data completes in the same cycle
        s0_cmd_address = 7'h22; s0_cmd_write = 1; s0_cmd_stop = 1; s0_cmd_valid = 1;
        s0_data_out = 8'h3C; s0_data_out_valid = 1; s0_data_out_last = 1;
        cyc();
        chk("same_grant", grant, 0);
        chk("same_s0drdy", s0_data_out_ready, 1);
        cyc();
        chk("same_direct_idle", busy, 0);
        s0_cmd_valid = 0; s0_cmd_write = 0; s0_cmd_stop = 0; s0_data_out_valid = 0; s0_data_out_last = 0;

        // reset mid-transaction on port 1, then both request
        s1_cmd_start = 1; s1_cmd_write = 1; s1_cmd_valid = 1;
        cyc();
        chk("mid_grant", grant, 1);
        chk("mid_mvalid", m_cmd_valid, 1);
        cyc();
        chk("mid_still_active", busy, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_mvalid", m_cmd_valid, 0);
        chk("mid_rst_s1rdy", s1_cmd_ready, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_grant", grant, 0);
        cyc();
        rst_n = 1'b1;
        s0_cmd_stop = 1; s0_cmd_valid = 1; s1_cmd_stop = 1;
        cyc();
        chk("post_rst_grant", grant, 0);
        s0_cmd_valid = 0; s1_cmd_valid = 0;
        cyc();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/i2c_cmd_arb.md
I2C_CMD_ARB -- requirements
Module: i2c_cmd_arb

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset, with ports named clk and rst_n.
REQ-002 Parameter ARB_RR, default 1, SHALL select the arbitration mode: 1 = round-robin between ports, 0 = fixed priority to port 0.
REQ-003 clk  input  1  Rising-edge clock for all state.
REQ-004 rst_n  input  1  Asynchronous active-low reset.
REQ-005 sN_cmd_address/start/read/write/write_multiple/stop/valid  input  7/1/1/1/1/1/1  Upstream command from port N (N=0,1); ready-valid handshake.
REQ-006 sN_cmd_ready  output  1  Port N command accepted.
REQ-007 sN_data_out, sN_data_out_valid, sN_data_out_last  input  8/1/1  Port N write-data stream.
REQ-008 sN_data_out_ready  output  1  Port N write data accepted.
REQ-009 sN_data_in, sN_data_in_valid, sN_data_in_last  output  8/1/1  Read data to port N.
REQ-010 sN_data_in_ready  input  1  Port N accepts read data.
REQ-011 m_cmd_*, m_data_out*  output, m_cmd_ready, m_data_out_ready  input  Same widths as REQ-005..008  Downstream command and write-data stream to the I2C master.
REQ-012 m_data_in, m_data_in_valid, m_data_in_last  input, m_data_in_ready  output  8/1/1/1  Downstream read data from the master.
REQ-013 grant  output  1  Index of the currently or most recently granted port.
REQ-014 busy  output  1  High while the state is not IDLE.

Function
REQ-015 The state machine SHALL have three states: IDLE, ACTIVE and DRAIN.
REQ-016 In IDLE, all sN ready signals and m valid signals SHALL be 0, and a request SHALL be defined as sN_cmd_valid=1.
REQ-017 In IDLE, a single request SHALL grant that port; on simultaneous requests, ARB_RR=1 SHALL grant the port other than last_grant and ARB_RR=0 SHALL grant port 0; the state SHALL go to ACTIVE at the next edge.
REQ-018 In ACTIVE and DRAIN, the granted port's cmd, data_out and data_in signals SHALL be connected combinationally to the m side with zero latency; valid/ready SHALL pass through unmodified.
REQ-019 The non-granted port SHALL see cmd_ready=0, data_out_ready=0 and data_in_valid=0 at all times.
REQ-020 The grant SHALL be held across multiple commands until a command with cmd_stop=1 completes an m_cmd handshake.
REQ-021 On a stop-command handshake, the block SHALL latch the pending data kind: write (write or write_multiple), read, or none.
REQ-022 Pending kind none SHALL return the state to IDLE at the next edge.
REQ-023 Pending kind write SHALL enter DRAIN until an m_data_out handshake with last=1; pending kind read SHALL enter DRAIN until an m_data_in handshake with last=1; the state SHALL then go to IDLE at the next edge.
REQ-024 A qualifying data handshake in the same cycle as the stop-command handshake SHALL go directly to IDLE.
REQ-025 In DRAIN, further commands from the granted port SHALL be blocked: m_cmd_valid=0 and sN_cmd_ready=0.
REQ-026 last_grant SHALL update on every entry to ACTIVE.
REQ-027 A port with no pending request SHALL never be granted, and IDLE with no request SHALL hold IDLE indefinitely.
REQ-028 The m_cmd_read output SHALL be the granted port's read bit; no field SHALL be altered by the block.

Reset
REQ-029 Assertion of rst_n (low) SHALL immediately force state IDLE, last_grant=1, grant=0, busy=0, and all valid/ready outputs to 0, including mid-transaction.
REQ-030 Reset SHALL be released synchronously: the first grant SHALL be evaluated on the first edge after rst_n rises.

Structure
REQ-031 The I2C field widths (address 7, data 8) SHALL come from the shared i2c definitions include; the state encoding SHALL remain local.
REQ-032 The IDLE-state grant selection SHALL be a sub-module, i2c_arb_rr, with 2 requests, a last_grant input, and grant index and valid outputs.

Verification
REQ-033 Port 0 alone sends start/write to address 0x50 with data 0x11, stop -> m sees address 0x50 and data 0x11 with last=1, busy falls the cycle after the data handshake, and port 1 is never ready.
REQ-034 Both ports request in the same IDLE cycle after reset -> port 0 is granted; when both request again, port 1 is granted (ARB_RR=1).
REQ-035 Port 1 issues a read of 0x51 with stop, and m_data_in_ready is delayed 5 cycles -> busy stays high through DRAIN; s1 receives the byte and s0 sees data_in_valid=0.
REQ-036 A stop-only command (all flags 0, stop=1) -> IDLE one cycle after the handshake with no DRAIN; a stop write whose data handshake falls in the same cycle -> direct to IDLE.
REQ-037 rst_n is pulsed low while in ACTIVE with m_cmd_valid=1 -> all valids drop immediately, and the next transaction grants port 0 first.
